// File: rtl/elevator_door_controller.sv
// rtl/elevator_door_controller.sv - car door sequencer with weight-counter clear and departure handshake
//
// Opens the door on floor arrival and holds it for OPEN_TIME cycles. It will not
// close while the weight limit is exceeded, and it asks the motion controller for
// departure through depart_req/depart_ack.
//
// Ports:
//   clock, reset_n         rising-edge clock, asynchronous active-low reset
//   arrive                 one-cycle pulse, car is level at a floor
//   call_pending           level, at least one outstanding floor call
//   open_button            level, door-open button is held
//   close_button           level, door-close button is held
//   obstruction            level, door-edge sensor is blocked
//   weight_limit_exceeded  level from the weight counter
//   door                   1 while the door is not fully closed
//   motor_open             door motor drive, open direction
//   motor_close            door motor drive, close direction
//   weight_flip_reset      one-cycle pulse that clears the weight counter
//   overload_alarm         buzzer/lamp, high while overloaded
//   depart_req             request to move the car
//   depart_ack             motion controller accepts the departure
module elevator_door_controller #(
    parameter int OPEN_TIME   = 50,
    parameter int TRAVEL_TIME = 10,
    parameter int TIMER_W     = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic arrive,
    input  logic call_pending,
    input  logic open_button,
    input  logic close_button,
    input  logic obstruction,
    input  logic weight_limit_exceeded,
    output logic door,
    output logic motor_open,
    output logic motor_close,
    output logic weight_flip_reset,
    output logic overload_alarm,
    output logic depart_req,
    input  logic depart_ack
);

    typedef enum logic [2:0] {
        CLOSED,
        WAIT_DEPART,
        MOVING,
        OPENING,
        OPEN_HOLD,
        OVERLOAD,
        CLOSING
    } state_t;

    localparam logic [TIMER_W-1:0] OPEN_LD   = TIMER_W'(OPEN_TIME);
    localparam logic [TIMER_W-1:0] TRAVEL_LD = TIMER_W'(TRAVEL_TIME);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    state_t             state;
    state_t             next_state;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] next_timer;
    logic               stroke_end;

    // A timed phase ends on the cycle the timer reads 1. Reading 0 also counts
    // as an end, so the saturated counter can never stall a phase.
    assign stroke_end = (timer <= TIMER_ONE);

    always_comb begin
        next_state = state;
        next_timer = (timer == '0) ? '0 : timer - TIMER_ONE;
        case (state)
            CLOSED: begin
                next_timer = '0;
                if (open_button) begin
                    next_state = OPENING;
                    next_timer = TRAVEL_LD;
                end else if (call_pending) begin
                    next_state = WAIT_DEPART;
                end
            end
            WAIT_DEPART: begin
                next_timer = '0;
                // An ack arriving together with the open button takes priority.
                if (depart_ack) begin
                    next_state = MOVING;
                end else if (open_button) begin
                    next_state = OPENING;
                    next_timer = TRAVEL_LD;
                end
            end
            MOVING: begin
                next_timer = '0;
                if (arrive) begin
                    next_state = OPENING;
                    next_timer = TRAVEL_LD;
                end
            end
            OPENING: begin
                if (stroke_end) begin
                    next_state = OPEN_HOLD;
                    next_timer = OPEN_LD;
                end
            end
            OPEN_HOLD: begin
                // Open beats close. Close makes the current cycle the last one
                // of the hold.
                if (open_button) begin
                    next_timer = OPEN_LD;
                end else if (close_button || stroke_end) begin
                    if (weight_limit_exceeded) begin
                        next_state = OVERLOAD;
                        next_timer = '0;
                    end else begin
                        next_state = CLOSING;
                        next_timer = TRAVEL_LD;
                    end
                end
            end
            OVERLOAD: begin
                next_timer = '0;
                if (!weight_limit_exceeded) begin
                    next_state = OPEN_HOLD;
                    next_timer = OPEN_LD;
                end
            end
            CLOSING: begin
                // Reopen is checked first, so it wins even on the final stroke cycle.
                if (obstruction || open_button || weight_limit_exceeded) begin
                    next_state = OPENING;
                    next_timer = TRAVEL_LD;
                end else if (stroke_end) begin
                    next_state = call_pending ? WAIT_DEPART : CLOSED;
                    next_timer = '0;
                end
            end
            default: begin
                next_state = CLOSED;
                next_timer = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state, so each output register holds the
    // value that matches the state register on the following cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= CLOSED;
            timer             <= '0;
            door              <= 1'b0;
            motor_open        <= 1'b0;
            motor_close       <= 1'b0;
            weight_flip_reset <= 1'b0;
            overload_alarm    <= 1'b0;
            depart_req        <= 1'b0;
        end else begin
            state             <= next_state;
            timer             <= next_timer;
            door              <= (next_state == OPENING) || (next_state == OPEN_HOLD) ||
                                 (next_state == OVERLOAD) || (next_state == CLOSING);
            motor_open        <= (next_state == OPENING);
            motor_close       <= (next_state == CLOSING);
            overload_alarm    <= (next_state == OVERLOAD);
            depart_req        <= (next_state == WAIT_DEPART);
            // The weight counter is cleared only on a new floor, never on a reopen.
            weight_flip_reset <= (state == MOVING) && arrive;
        end
    end

endmodule

// File: tb/tb_elevator_door_controller.sv
// tb/tb_elevator_door_controller.sv - scoreboard bench for elevator_door_controller
module tb_elevator_door_controller;

    logic clock;
    logic reset_n;
    logic arrive;
    logic call_pending;
    logic open_button;
    logic close_button;
    logic obstruction;
    logic weight_limit_exceeded;
    logic door;
    logic motor_open;
    logic motor_close;
    logic weight_flip_reset;
    logic overload_alarm;
    logic depart_req;
    logic depart_ack;

    // Output vector: {door, motor_open, motor_close, weight_flip_reset, overload_alarm, depart_req}
    localparam logic [5:0] O_IDLE     = 6'b000000;
    localparam logic [5:0] O_DREQ     = 6'b000001;
    localparam logic [5:0] O_FLIPOPEN = 6'b110100;
    localparam logic [5:0] O_OPENING  = 6'b110000;
    localparam logic [5:0] O_HOLD     = 6'b100000;
    localparam logic [5:0] O_CLOSING  = 6'b101000;
    localparam logic [5:0] O_OVER     = 6'b100010;

    logic [5:0] exp_q[$];
    string      name_q[$];
    int         checks;
    int         failures;

    elevator_door_controller #(
        .OPEN_TIME(50),
        .TRAVEL_TIME(10),
        .TIMER_W(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .arrive(arrive),
        .call_pending(call_pending),
        .open_button(open_button),
        .close_button(close_button),
        .obstruction(obstruction),
        .weight_limit_exceeded(weight_limit_exceeded),
        .door(door),
        .motor_open(motor_open),
        .motor_close(motor_close),
        .weight_flip_reset(weight_flip_reset),
        .overload_alarm(overload_alarm),
        .depart_req(depart_req),
        .depart_ack(depart_ack)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Monitor: compares every scheduled expectation on the falling edge.
    initial begin
        logic [5:0] got;
        logic [5:0] want;
        string      nm;
        checks   = 0;
        failures = 0;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                nm   = name_q.pop_front();
                got  = {door, motor_open, motor_close, weight_flip_reset, overload_alarm, depart_req};
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL %s actual=%b required=%b at %0t", nm, got, want, $time);
                end
            end
        end
    end

    task automatic run(input int n, input logic [5:0] exp, input string nm);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            exp_q.push_back(exp);
            name_q.push_back(nm);
            @(negedge clock);
        end
    endtask

    task automatic async_reset_check();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.push_back(O_IDLE);
        name_q.push_back("async_reset");
        @(negedge clock);
    endtask

    initial begin
        reset_n               = 1'b0;
        arrive                = 1'b0;
        call_pending          = 1'b0;
        open_button           = 1'b0;
        close_button          = 1'b0;
        obstruction           = 1'b0;
        weight_limit_exceeded = 1'b0;
        depart_ack            = 1'b0;

        run(2, O_IDLE, "reset_state");
        reset_n = 1'b1;
        run(2, O_IDLE, "closed_idle");
        arrive = 1'b1;
        run(1, O_IDLE, "arrive_in_closed");
        arrive = 1'b0;
        run(1, O_IDLE, "closed_idle2");

        call_pending = 1'b1;
        run(1, O_DREQ, "dreq_rise");
        run(5, O_DREQ, "dreq_hold");
        depart_ack = 1'b1;
        run(1, O_IDLE, "ack_to_moving");
        depart_ack   = 1'b0;
        call_pending = 1'b0;
        run(2, O_IDLE, "moving");
        open_button = 1'b1;
        run(2, O_IDLE, "moving_open_ignored");
        open_button = 1'b0;

        arrive = 1'b1;
        run(1, O_FLIPOPEN, "arrive_flip");
        arrive = 1'b0;
        run(9, O_OPENING, "opening_stroke");
        run(50, O_HOLD, "open_hold");
        run(10, O_CLOSING, "closing_stroke");
        run(2, O_IDLE, "closed_after_cycle");

        open_button = 1'b1;
        run(1, O_OPENING, "open_from_closed");
        open_button = 1'b0;
        run(9, O_OPENING, "opening_stroke2");
        run(45, O_HOLD, "hold_pre_overload");
        weight_limit_exceeded = 1'b1;
        run(5, O_HOLD, "hold_pre_overload_end");
        run(3, O_OVER, "overload");
        weight_limit_exceeded = 1'b0;
        run(50, O_HOLD, "hold_after_overload");
        run(9, O_CLOSING, "closing_pre_obstruction");
        obstruction = 1'b1;
        run(1, O_OPENING, "obstruction_reopen");
        obstruction = 1'b0;
        run(9, O_OPENING, "reopen_stroke");

        run(3, O_HOLD, "hold_pre_close_button");
        close_button = 1'b1;
        run(1, O_CLOSING, "close_button");
        close_button = 1'b0;
        run(9, O_CLOSING, "closing_to_final");
        open_button = 1'b1;
        run(1, O_OPENING, "reopen_final_cycle");
        open_button = 1'b0;
        run(9, O_OPENING, "reopen_stroke2");

        run(40, O_HOLD, "hold_pre_both");
        open_button  = 1'b1;
        close_button = 1'b1;
        run(1, O_HOLD, "both_buttons");
        open_button  = 1'b0;
        close_button = 1'b0;
        run(49, O_HOLD, "hold_restarted");
        run(4, O_CLOSING, "closing_pre_reset");

        async_reset_check();
        run(2, O_IDLE, "held_in_reset");
        reset_n = 1'b1;
        run(2, O_IDLE, "post_reset_idle");

        call_pending = 1'b1;
        run(1, O_DREQ, "closed_after_reset");
        open_button = 1'b1;
        run(1, O_OPENING, "open_while_waiting");
        open_button  = 1'b0;
        call_pending = 1'b0;
        run(9, O_OPENING, "opening_stroke3");
        run(50, O_HOLD, "open_hold3");
        run(9, O_CLOSING, "closing_stroke3");
        call_pending = 1'b1;
        run(1, O_CLOSING, "closing_last");
        run(1, O_DREQ, "close_to_wait");
        open_button = 1'b1;
        depart_ack  = 1'b1;
        run(1, O_IDLE, "ack_beats_open");
        open_button  = 1'b0;
        depart_ack   = 1'b0;
        call_pending = 1'b0;
        run(2, O_IDLE, "moving_final");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
        @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/elevator_door_controller.md
Name: elevator_door_controller

Overview:
Cycle-based sequencer for the car door and the passenger weight counter.
- Opens the door on floor arrival and holds it open for a programmable time.
- Refuses to close while the weight limit is exceeded.
- Clears the weight counter at each new floor.
- Requests departure through a req/ack handshake with the motion controller.
- Sits between the motion controller, the car buttons and the weight counter; its door output feeds the weight counter's door input.

Parameters:
OPEN_TIME, 50, cycles the door stays fully open before auto-close (>=1)
TRAVEL_TIME, 10, cycles for a full open or close stroke (>=1)
TIMER_W, 8, timer width; must hold max(OPEN_TIME, TRAVEL_TIME)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
arrive  in  1  one-cycle pulse: car stopped level at a floor
call_pending  in  1  level: at least one outstanding floor call
open_button  in  1  level: door-open button held
close_button  in  1  level: door-close button held
obstruction  in  1  level: door-edge sensor blocked
weight_limit_exceeded  in  1  level from weight counter
door  out  1  1 = door not fully closed (OPENING/OPEN_HOLD/OVERLOAD/CLOSING)
motor_open  out  1  door motor drive, open direction
motor_close  out  1  door motor drive, close direction
weight_flip_reset  out  1  one-cycle pulse clearing the weight counter
overload_alarm  out  1  buzzer/lamp, high in OVERLOAD
depart_req  out  1  request to move the car
depart_ack  in  1  motion controller accepts departure

Behaviour:
Reset and registers:
- reset_n low (async): state=CLOSED, timer=0; all outputs 0. Overrides everything, including mid-stroke.
- All outputs are registered; they reflect the current state and change one cycle after the causing input is sampled.

Timer and stroke rules:
- Timer is a TIMER_W-bit down-counter, saturating at 0; it never wraps.
- A stroke ends on the cycle the timer reads 1, so a stroke lasts exactly TRAVEL_TIME cycles in OPENING or CLOSING.

States and transitions:
- CLOSED: door=0.
  - open_button=1 -> OPENING.
  - else call_pending=1 -> WAIT_DEPART.
  - arrive is ignored here.
- WAIT_DEPART: depart_req=1, held until depart_ack=1 is sampled -> MOVING; depart_req drops in that same transition.
  - open_button while waiting (before ack) -> OPENING, depart_req=0.
  - ack and open_button in the same cycle: ack wins.
- MOVING: depart_req=0, door=0; open_button and close_button ignored.
  - arrive=1 -> OPENING; weight_flip_reset pulses for exactly 1 cycle on this transition.
- OPENING: motor_open=1, door=1; timer loaded TRAVEL_TIME on entry; at end -> OPEN_HOLD with timer=OPEN_TIME.
- OPEN_HOLD: door=1, motors off; timer decrements each cycle.
  - open_button=1 reloads OPEN_TIME.
  - close_button=1 (and open_button=0) forces timer to 1.
  - Both buttons high: open wins.
  - Timer end: weight_limit_exceeded=1 -> OVERLOAD; else -> CLOSING.
- OVERLOAD: door=1, overload_alarm=1, motors off.
  - weight_limit_exceeded=0 -> OPEN_HOLD with timer=OPEN_TIME.
  - Buttons ignored.
- CLOSING: motor_close=1, door=1; timer loaded TRAVEL_TIME on entry.
  - Any of obstruction, open_button or weight_limit_exceeded -> OPENING (full TRAVEL_TIME reopen).
  - Reopen is checked before stroke end, so a reopen condition on the final cycle wins.
  - At end: call_pending=1 -> WAIT_DEPART, else -> CLOSED.

Invariants:
- motor_open and motor_close are never both 1.
- depart_req=1 only while door=0.
- weight_flip_reset fires only on the MOVING->OPENING transition; a reopen never pulses it.
- arrive outside MOVING is ignored.

Test Plan:
- Reset, call_pending=0 -> all outputs 0, state CLOSED. Pulse arrive -> no change.
- call_pending=1 from CLOSED -> depart_req=1 next cycle. Hold ack low 5 cycles -> depart_req stays 1. ack=1 -> depart_req=0 next cycle.
- In MOVING, pulse arrive -> weight_flip_reset high 1 cycle, motor_open high 10 cycles, then door=1 open 50 cycles, then motor_close 10 cycles, then door=0 (defaults).
- OPEN_HOLD with weight_limit_exceeded=1 at timeout -> overload_alarm=1, door stays 1. Drop limit -> alarm 0, full 50-cycle hold, then close.
- obstruction=1 on cycle 9 of CLOSING -> motor_close=0, motor_open=1 next cycle for 10 cycles. No weight_flip_reset.
- OPEN_HOLD, close_button at cycle 3 -> CLOSING begins next cycle. open_button+close_button together -> hold restarts at 50.
- Assert reset_n low mid-CLOSING -> all outputs 0 immediately (asynchronous). After release, state is CLOSED.
